// File: rtl/cpu_pkg.sv
// cpu_pkg: shared widths, reset PC, fetch FSM states and fetch entry type
package cpu_pkg;
  localparam int ADDR_W = 10;
  localparam int INSTR_W = 16;
  localparam logic [ADDR_W-1:0] RESET_PC = 10'h000;
  localparam logic [1:0] FIFO_DEPTH = 2'd2;
  typedef enum logic [1:0] {F_IDLE, F_WAIT, F_DROP} fetch_state_t;
  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/instr_fifo.sv
// instr_fifo: two-entry shift FIFO of fetch entries; flush overrides push and pop
module instr_fifo
  import cpu_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t din,
  output logic [1:0]   count,
  output fetch_entry_t head,
  output logic         valid
);
  fetch_entry_t r_mem [2];
  logic [1:0] r_count;
  logic w_pop;
  logic w_slot;
  assign w_pop = pop && r_count != 2'd0;
  assign w_slot = r_count[1] | (r_count[0] & !w_pop);
  // shift out the head on pop, then write the new entry into the first free slot
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_count <= 2'd0;
    end else if (flush) begin
      r_count <= 2'd0;
    end else begin
      if (w_pop) r_mem[0] <= r_mem[1];
      if (push) r_mem[w_slot] <= din;
      r_count <= r_count + {1'b0, push} - {1'b0, w_pop};
    end
  end
  assign count = r_count;
  assign head = r_mem[0];
  assign valid = r_count != 2'd0;
endmodule

// File: rtl/instruction_fetch.sv
// instruction_fetch: PC owner, single-outstanding program-memory reader and prefetch buffer
module instruction_fetch
  import cpu_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  output logic               pmem_req,
  output logic [ADDR_W-1:0]  pmem_addr,
  input  logic               pmem_ack,
  input  logic [INSTR_W-1:0] pmem_rdata,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc,
  input  logic               instr_ready,
  input  logic               jump_en,
  input  logic [ADDR_W-1:0]  jump_addr,
  input  logic               halt
);
  fetch_state_t r_state;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_addr;
  logic r_req;
  logic [1:0] w_count;
  logic [1:0] w_count_next;
  logic w_push;
  logic w_pop;
  logic w_can;
  fetch_entry_t w_head;
  assign w_push = r_state == F_WAIT && pmem_ack && !jump_en;
  assign w_pop = instr_valid && instr_ready && !jump_en;
  assign w_count_next = jump_en ? 2'd0 : w_count + {1'b0, w_push} - {1'b0, w_pop};
  assign w_can = !halt && w_count_next < FIFO_DEPTH;
  instr_fifo u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (w_push),
    .pop   (w_pop),
    .flush (jump_en),
    .din   ({r_addr, pmem_rdata}),
    .count (w_count),
    .head  (w_head),
    .valid (instr_valid)
  );
  // sequencer: a read still in flight at a redirect is drained in F_DROP; otherwise the target issues at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= F_IDLE;
      r_pc <= RESET_PC;
      r_addr <= RESET_PC;
      r_req <= 1'b0;
    end else if (jump_en && r_state != F_IDLE && !pmem_ack) begin
      r_pc <= jump_addr;
      r_state <= F_DROP;
    end else if (jump_en) begin
      r_pc <= halt ? jump_addr : jump_addr + 1'b1;
      r_addr <= halt ? r_addr : jump_addr;
      r_req <= !halt;
      r_state <= halt ? F_IDLE : F_WAIT;
    end else if (r_state == F_IDLE || pmem_ack) begin
      r_addr <= w_can ? r_pc : r_addr;
      r_pc <= w_can ? r_pc + 1'b1 : r_pc;
      r_req <= w_can;
      r_state <= w_can ? F_WAIT : F_IDLE;
    end
  end
  assign pmem_req = r_req;
  assign pmem_addr = r_addr;
  assign instr = w_head.instr;
  assign instr_pc = w_head.pc;
  // the issue rule only lets a read start when its result will have room
  assert property (@(posedge clk) disable iff (!rst_n) !(w_push && w_count == FIFO_DEPTH));
endmodule
